subtrator8bits_serial: RTL
==========================

# subtrator8bits_serial

Bit-serial 8-bit two's-complement subtractor, the counterpart to the team's combinational 8-bit adder. It computes diferenca = a − b one bit per clock, LSB first, with a start/done handshake. It reports signed overflow (f) and unsigned borrow (emprestimo). It is the datapath's area-cheap subtract unit for paths that tolerate multi-cycle latency.

## Interface
Parameters: none (width fixed at 8).

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- inicio  input  1  start request; sampled only in state OCIOSO
- a  input  8  minuend, captured on the accepting edge
- b  input  8  subtrahend, captured on the accepting edge
- ocupado  output  1  high while state is CALCULA
- pronto  output  1  one-cycle pulse; results valid
- diferenca  output  8  a − b mod 256, held until the next accept
- f  output  1  signed overflow of a − b, held with diferenca
- emprestimo  output  1  unsigned borrow (a < b), held with diferenca

## Operation
- FSM states: OCIOSO, CALCULA, FIM.
  - OCIOSO with inicio=1: a and b are captured into shift registers, the bit counter is cleared, the borrow flop is cleared, and the FSM moves to CALCULA. inicio=0 stays in OCIOSO.
  - CALCULA: one bit i per edge, i = 0..7.
    - d_i = a_i ^ b_i ^ br.
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
    - d_i shifts into the result register MSB-side, so after 8 shifts bit i lands at position i.
    - After bit 7 the FSM goes to FIM.
  - FIM: pronto=1 for exactly one cycle, then back to OCIOSO unconditionally.
- On the edge computing bit 7, update:
  - diferenca with the full result.
  - emprestimo = final br.
  - f = (a7 != b7) & (d7 != a7), using the captured operands.
- inicio is ignored in CALCULA and FIM. It is not queued. Back-to-back operations need inicio high in OCIOSO, which gives a 10-cycle minimum issue interval.
- Changes to a/b after the accepting edge have no effect.
- diferenca/f/emprestimo update only at completion. During CALCULA they keep the previous result; partial bits are never visible.
- Reset (asynchronous assert, any state, including mid-CALCULA):
  - FSM → OCIOSO.
  - All outputs → 0: ocupado=0, pronto=0, diferenca=8'h00, f=0, emprestimo=0.
  - Shift registers, counter and borrow are cleared.
  - An aborted operation produces no pronto.

## Timing
- Edge T0: inicio=1 in OCIOSO. ocupado=1 from after T0.
- Edges T1..T8: bits 0..7. Results are registered at T8. After T8: ocupado=0, pronto=1.
- Edge T9: pronto=0, FSM back in OCIOSO. Latency from accept to pronto high is 8 cycles.
- ocupado and pronto are never high together. Both are registered (Moore) outputs.

## Configuration
- SUBTRATOR_SATURA_EN defined: on signed overflow, diferenca saturates.
  - a7=0 (positive overflow) → 8'h7F.
  - a7=1 (negative overflow) → 8'h80.
  - f and emprestimo are unchanged (f still reports overflow).
  - Latency is identical.
- Not defined: diferenca is the raw wrap-around result (mod 256).

## Test plan
- Reset: hold rst_n=0 → all outputs 0 and FSM in OCIOSO. Release, idle 5 cycles → pronto never pulses.
- a=8'd100, b=8'd58, inicio pulse → ocupado high 8 cycles, then pronto one cycle with diferenca=8'h2A, f=0, emprestimo=0.
- a=8'h05, b=8'h0A → diferenca=8'hFB, f=0, emprestimo=1.
- a=8'h80, b=8'h01 → f=1, emprestimo=0; diferenca=8'h7F without SUBTRATOR_SATURA_EN, 8'h80 with it.
- a=8'h7F, b=8'hFF → f=1, emprestimo=1; diferenca=8'h80 without SUBTRATOR_SATURA_EN, 8'h7F with it.
- Start a=8'h10, b=8'h01, then:
  - Change a/b and pulse inicio at T3 → ignored; result is 8'h0F at T8.
  - Repeat, asserting rst_n=0 at T4 → outputs 0 immediately, no pronto; a new operation afterwards completes normally.

Source files
------------

// File: rtl/subtrator8bits_serial_if.sv
// Handshake and operand/result bundle for the bit-serial 8-bit subtractor.
// master: the requester that issues inicio/a/b; slave: the subtractor itself.
interface subtrator8bits_serial_if;
    logic       inicio;
    logic [7:0] a;
    logic [7:0] b;
    logic       ocupado;
    logic       pronto;
    logic [7:0] diferenca;
    logic       f;
    logic       emprestimo;

    modport master (
        output inicio,
        output a,
        output b,
        input  ocupado,
        input  pronto,
        input  diferenca,
        input  f,
        input  emprestimo
    );

    modport slave (
        input  inicio,
        input  a,
        input  b,
        output ocupado,
        output pronto,
        output diferenca,
        output f,
        output emprestimo
    );
endinterface

// File: rtl/subtrator8bits_serial.sv
// Bit-serial 8-bit two's-complement subtractor: diferenca = a - b, one bit per
// clock, LSB first, with an inicio/pronto handshake. Reports signed overflow (f)
// and unsigned borrow (emprestimo). Results change only at completion.
// Optional build macro SUBTRATOR_SATURA_EN: saturate diferenca on signed overflow
// (8'h7F for positive overflow, 8'h80 for negative); f/emprestimo unaffected.
module subtrator8bits_serial (
    input  logic                          clk,
    input  logic                          rst_n,
    subtrator8bits_serial_if.slave        bus
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // One full-subtractor bit: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bin);
        logic d;
        logic bout;
        d    = ai ^ bi ^ bin;
        bout = (~ai & bi) | (~(ai ^ bi) & bin);
        return {bout, d};
    endfunction

    estado_t    estado_r;
    estado_t    prox_s;

    logic [7:0] a_sr_r;
    logic [7:0] b_sr_r;
    logic [7:0] res_sr_r;
    logic [2:0] cnt_r;
    logic       br_r;

    logic       ocupado_r;
    logic       pronto_r;
    logic [7:0] diferenca_r;
    logic       f_r;
    logic       emprestimo_r;

    logic       carrega_s;
    logic       desloca_s;
    logic       ultimo_s;
    logic [1:0] bit_s;
    logic [7:0] res_full_s;
    logic       ovf_s;
    logic [7:0] res_final_s;

    // Current-bit datapath: the operand shift registers always present bit i at [0].
    always_comb begin
        bit_s      = sub_bit(a_sr_r[0], b_sr_r[0], br_r);
        res_full_s = {bit_s[0], res_sr_r[7:1]};
        // On the last bit a_sr_r[0]/b_sr_r[0] hold the captured sign bits a7/b7.
        ovf_s      = (a_sr_r[0] != b_sr_r[0]) & (bit_s[0] != a_sr_r[0]);
`ifdef SUBTRATOR_SATURA_EN
        if (ovf_s) begin
            res_final_s = a_sr_r[0] ? 8'h80 : 8'h7F;
        end else begin
            res_final_s = res_full_s;
        end
`else
        res_final_s = res_full_s;
`endif
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        prox_s    = estado_r;
        carrega_s = 1'b0;
        desloca_s = 1'b0;
        ultimo_s  = 1'b0;
        case (estado_r)
            OCIOSO: begin
                if (bus.inicio) begin
                    carrega_s = 1'b1;
                    prox_s    = CALCULA;
                end else begin
                    prox_s    = OCIOSO;
                end
            end
            CALCULA: begin
                desloca_s = 1'b1;
                if (cnt_r == 3'd7) begin
                    ultimo_s = 1'b1;
                    prox_s   = FIM;
                end else begin
                    prox_s   = CALCULA;
                end
            end
            FIM: begin
                prox_s = OCIOSO;
            end
            default: begin
                prox_s = OCIOSO;
            end
        endcase
    end

    // State register plus Moore status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r  <= OCIOSO;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b0;
        end else begin
            estado_r  <= prox_s;
            ocupado_r <= (prox_s == CALCULA);
            pronto_r  <= (prox_s == FIM);
        end
    end

    // Operand capture, serial shift/borrow chain and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r       <= 8'h00;
            b_sr_r       <= 8'h00;
            res_sr_r     <= 8'h00;
            cnt_r        <= 3'd0;
            br_r         <= 1'b0;
            diferenca_r  <= 8'h00;
            f_r          <= 1'b0;
            emprestimo_r <= 1'b0;
        end else if (carrega_s) begin
            a_sr_r <= bus.a;
            b_sr_r <= bus.b;
            cnt_r  <= 3'd0;
            br_r   <= 1'b0;
        end else if (desloca_s) begin
            a_sr_r   <= {1'b0, a_sr_r[7:1]};
            b_sr_r   <= {1'b0, b_sr_r[7:1]};
            res_sr_r <= res_full_s;
            cnt_r    <= cnt_r + 3'd1;
            br_r     <= bit_s[1];
            if (ultimo_s) begin
                diferenca_r  <= res_final_s;
                f_r          <= ovf_s;
                emprestimo_r <= bit_s[1];
            end
        end
    end

    assign bus.ocupado    = ocupado_r;
    assign bus.pronto     = pronto_r;
    assign bus.diferenca  = diferenca_r;
    assign bus.f          = f_r;
    assign bus.emprestimo = emprestimo_r;

endmodule
